// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin ALU/RF frame scheduler that paces single-byte
// transfers into the UART transmitter on its Busy flag, with bounded retries.
module uart_tx_sched #(
  parameter int WIDTH = 8,
  parameter int RETRY_CYC = 8,
  parameter int MAX_TRY = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2*WIDTH-1:0] ALU_OUT,
  input  logic               ALU_REQ,
  output logic               ALU_GNT,
  input  logic [WIDTH-1:0]   RF_RD_DATA,
  input  logic               RF_REQ,
  output logic               RF_GNT,
  input  logic               TX_BUSY,
  output logic [WIDTH-1:0]   TX_P_DATA,
  output logic               TX_D_VLD,
  output logic               SCHED_BUSY,
  output logic               TX_ERR
);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, WAIT_HI = 2'd2, WAIT_LO = 2'd3;
  localparam int WW = RETRY_CYC > 1 ? $clog2(RETRY_CYC) : 1;
  localparam int TW = $clog2(MAX_TRY + 1);
  logic [1:0] state, left;
  logic last_rf, pick_alu, req, retry_end;
  logic [WIDTH-1:0] hi;
  logic [WW-1:0] wcnt;
  logic [TW-1:0] tries;
  // last_rf resets high so the ALU wins the first tie
  always_comb begin
    pick_alu = ALU_REQ && (!RF_REQ || last_rf);
    req = ALU_REQ || RF_REQ;
    retry_end = wcnt == WW'(RETRY_CYC - 1);
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      left <= '0;
      last_rf <= 1'b1;
      hi <= '0;
      wcnt <= '0;
      tries <= '0;
      ALU_GNT <= 1'b0;
      RF_GNT <= 1'b0;
      TX_P_DATA <= '0;
      TX_D_VLD <= 1'b0;
      SCHED_BUSY <= 1'b0;
      TX_ERR <= 1'b0;
    end else begin
      ALU_GNT <= 1'b0;
      RF_GNT <= 1'b0;
      TX_D_VLD <= 1'b0;
      TX_ERR <= 1'b0;
      case (state)
        IDLE: if (req && !TX_BUSY) begin
          state <= SEND;
          SCHED_BUSY <= 1'b1;
          TX_D_VLD <= 1'b1;
          tries <= TW'(1);
          last_rf <= !pick_alu;
          ALU_GNT <= pick_alu;
          RF_GNT <= !pick_alu;
          TX_P_DATA <= pick_alu ? ALU_OUT[WIDTH-1:0] : RF_RD_DATA;
          hi <= ALU_OUT[2*WIDTH-1:WIDTH];
          left <= pick_alu ? 2'd2 : 2'd1;
        end
        SEND: begin
          state <= WAIT_HI;
          wcnt <= '0;
        end
        WAIT_HI: if (TX_BUSY) begin
          state <= WAIT_LO;
          tries <= '0;
        end else if (retry_end) begin
          if (tries < TW'(MAX_TRY)) begin
            state <= SEND;
            TX_D_VLD <= 1'b1;
            tries <= tries + 1'b1;
          end else begin
            state <= IDLE;
            SCHED_BUSY <= 1'b0;
            TX_ERR <= 1'b1;
            left <= '0;
          end
        end else wcnt <= wcnt + 1'b1;
        default: if (!TX_BUSY) begin
          if (left > 2'd1) begin
            state <= SEND;
            left <= left - 1'b1;
            TX_P_DATA <= hi;
            TX_D_VLD <= 1'b1;
            tries <= TW'(1);
          end else begin
            state <= IDLE;
            SCHED_BUSY <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: table-driven and randomized frames against a frame-level
// model, with a responsive UART Busy model and hand-written timing corners.
module tb_uart_tx_sched;
  localparam int RETRY_CYC = 8;
  localparam int MAX_TRY = 3;
  logic CLK = 0, RST;
  logic [15:0] ALU_OUT;
  logic ALU_REQ, ALU_GNT, RF_REQ, RF_GNT, TX_BUSY, TX_D_VLD, SCHED_BUSY, TX_ERR;
  logic [7:0] RF_RD_DATA, TX_P_DATA;

  uart_tx_sched #(.WIDTH(8), .RETRY_CYC(RETRY_CYC), .MAX_TRY(MAX_TRY)) dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .ALU_REQ(ALU_REQ), .ALU_GNT(ALU_GNT),
    .RF_RD_DATA(RF_RD_DATA), .RF_REQ(RF_REQ), .RF_GNT(RF_GNT), .TX_BUSY(TX_BUSY),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .SCHED_BUSY(SCHED_BUSY), .TX_ERR(TX_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic a, r;
    logic [15:0] ao;
    logic [7:0] rd;
    int ig, blen, ng;
    logic g0, g1;
    int nb;
    logic [23:0] b;
    logic err;
  } vec_t;
  vec_t tbl[9];

  int checks = 0, failures = 0, cyc = 0, en = 0, err_t = 0, sb_t = 0;
  int resp_ignore = 0, resp_len = 4;
  int gq[$], eg[$], dv_t[$], bf_t[$];
  logic [7:0] bq[$], eb[$];
  logic ee, m_last_rf, pb;
  logic prev_dv = 0, prev_busy = 0, prev_sb = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    gq.delete(); bq.delete(); dv_t.delete(); bf_t.delete(); en = 0;
  endtask

  // UART transmitter model: ignores the next resp_ignore presentations, then
  // holds Busy for resp_len cycles, switching just after the clock edge
  initial begin
    TX_BUSY = 0;
    forever begin
      @(posedge CLK); #1;
      if (TX_D_VLD) begin
        if (resp_ignore > 0) resp_ignore--;
        else begin
          TX_BUSY = 1;
          repeat (resp_len) @(posedge CLK);
          #1 TX_BUSY = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    cyc++;
    if (TX_D_VLD) begin
      chk("dvld_gap", {31'd0, prev_dv}, 32'd0);
      bq.push_back(TX_P_DATA);
      dv_t.push_back(cyc);
    end
    prev_dv = TX_D_VLD;
    if (ALU_GNT) gq.push_back(0);
    if (RF_GNT) gq.push_back(1);
    if (TX_ERR) begin en++; err_t = cyc; end
    if (prev_busy && !TX_BUSY) bf_t.push_back(cyc);
    prev_busy = TX_BUSY;
    if (prev_sb && !SCHED_BUSY) sb_t = cyc;
    prev_sb = SCHED_BUSY;
  end

  // frame-level expectation: grant order from round-robin, bytes per frame,
  // first byte repeated once per ignored presentation up to MAX_TRY
  task automatic build_exp(input logic a, input logic r, input logic [15:0] ao,
                           input logic [7:0] rd, input int ig);
    int who, nb;
    logic [7:0] by;
    eg.delete(); eb.delete(); ee = 0;
    for (int f = 0; f < ((a && r) ? 2 : 1); f++) begin
      who = (f == 0) ? ((a && r) ? (m_last_rf ? 0 : 1) : (a ? 0 : 1)) : 1 - eg[0];
      eg.push_back(who);
      m_last_rf = (who == 1);
      nb = (who == 0) ? 2 : 1;
      for (int j = 0; j < nb; j++) begin
        by = (who == 1) ? rd : (j == 0 ? ao[7:0] : ao[15:8]);
        if (f == 0 && j == 0 && ig >= MAX_TRY) begin
          repeat (MAX_TRY) eb.push_back(by);
          ee = 1;
          break;
        end
        repeat ((f == 0 && j == 0) ? ig + 1 : 1) eb.push_back(by);
      end
    end
  endtask

  task automatic episode(input logic a, input logic r, input logic [15:0] ao,
                         input logic [7:0] rd, input int ig, input int blen);
    int k;
    @(posedge CLK);
    clear_mon();
    resp_ignore = ig;
    resp_len = blen;
    @(negedge CLK);
    ALU_OUT = ao; RF_RD_DATA = rd; ALU_REQ = a; RF_REQ = r;
    @(negedge CLK);
    chk("latency", {29'd0, ALU_GNT | RF_GNT, TX_D_VLD, SCHED_BUSY}, 32'd7);
    for (k = 0; k < 400; k++) begin
      if (ALU_GNT) ALU_REQ = 0;
      if (RF_GNT) RF_REQ = 0;
      if (!ALU_REQ && !RF_REQ && !SCHED_BUSY && !TX_BUSY) break;
      @(negedge CLK);
    end
    chk("episode_done", {31'd0, k < 400}, 32'd1);
    ALU_REQ = 0; RF_REQ = 0;
    @(posedge CLK);
    chk("gnt_count", gq.size(), eg.size());
    foreach (eg[i]) if (i < gq.size()) chk("gnt_order", gq[i], eg[i]);
    chk("byte_count", bq.size(), eb.size());
    foreach (eb[i]) if (i < bq.size()) chk("byte", {24'd0, bq[i]}, {24'd0, eb[i]});
    chk("tx_err", en, {31'd0, ee});
    if (!ee && bf_t.size() > 0) chk("sb_fall", sb_t - bf_t[bf_t.size()-1], 1);
  endtask

  initial begin
    int k, kind, ig;
    logic [15:0] ao;
    logic [7:0] rd;
    ALU_REQ = 0; RF_REQ = 0; ALU_OUT = 0; RF_RD_DATA = 0;
    RST = 1;
    #3 RST = 0;
    #1 chk("rst_outs", {19'd0, ALU_GNT, RF_GNT, TX_D_VLD, TX_P_DATA, SCHED_BUSY, TX_ERR}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1;
    repeat (3) @(negedge CLK);
    chk("idle_outs", {19'd0, ALU_GNT, RF_GNT, TX_D_VLD, TX_P_DATA, SCHED_BUSY, TX_ERR}, 32'd0);

    tbl[0] = '{1, 1, 16'h1234, 8'hA5, 0, 10, 2, 0, 1, 3, 24'h3412A5, 0};
    tbl[1] = '{0, 1, 16'h0000, 8'hA5, 0, 10, 1, 1, 0, 1, 24'hA50000, 0};
    tbl[2] = '{1, 0, 16'h1234, 8'h00, 0, 5, 1, 0, 0, 2, 24'h341200, 0};
    tbl[3] = '{1, 1, 16'hBEEF, 8'h11, 0, 3, 2, 1, 0, 3, 24'h11EFBE, 0};
    tbl[4] = '{0, 1, 16'h0000, 8'h5A, 0, 4, 1, 1, 0, 1, 24'h5A0000, 0};
    tbl[5] = '{1, 1, 16'hCAFE, 8'h77, 0, 2, 2, 0, 1, 3, 24'hFECA77, 0};
    tbl[6] = '{0, 1, 16'h0000, 8'h3C, 3, 4, 1, 1, 0, 3, 24'h3C3C3C, 1};
    tbl[7] = '{1, 0, 16'h5566, 8'h00, 1, 6, 1, 0, 0, 3, 24'h666655, 0};
    tbl[8] = '{1, 0, 16'hAABB, 8'h00, 3, 4, 1, 0, 0, 3, 24'hBBBBBB, 1};
    for (int i = 0; i < 9; i++) begin
      eg.delete(); eb.delete();
      eg.push_back(int'(tbl[i].g0));
      if (tbl[i].ng == 2) eg.push_back(int'(tbl[i].g1));
      for (int j = 0; j < tbl[i].nb; j++) eb.push_back(tbl[i].b[23-8*j -: 8]);
      ee = tbl[i].err;
      episode(tbl[i].a, tbl[i].r, tbl[i].ao, tbl[i].rd, tbl[i].ig, tbl[i].blen);
      if (i == 2 && dv_t.size() > 1 && bf_t.size() > 0)
        chk("next_byte_lat", dv_t[1] - bf_t[0], 1);
      if (i == 6 && dv_t.size() > 2) begin
        chk("retry_gap1", dv_t[1] - dv_t[0], RETRY_CYC + 1);
        chk("retry_gap2", dv_t[2] - dv_t[1], RETRY_CYC + 1);
        chk("err_lat", err_t - dv_t[0], MAX_TRY * (RETRY_CYC + 1));
      end
    end

    m_last_rf = 0;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      ig = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      ao = 16'($urandom);
      rd = 8'($urandom);
      build_exp(kind != 1, kind != 0, ao, rd, ig);
      episode(kind != 1, kind != 0, ao, rd, ig, $urandom_range(2, 12));
    end

    // reset between the two ALU bytes, with an RF request pending across it
    resp_ignore = 0;
    resp_len = 8;
    @(posedge CLK);
    clear_mon();
    @(negedge CLK);
    ALU_OUT = 16'h1234; ALU_REQ = 1;
    k = 0;
    while (!ALU_GNT && k < 50) begin @(negedge CLK); k++; end
    ALU_REQ = 0;
    while (!TX_BUSY && k < 50) begin @(negedge CLK); k++; end
    chk("rst_mid_reach", {31'd0, k < 50}, 32'd1);
    @(negedge CLK);
    RF_RD_DATA = 8'h99; RF_REQ = 1; RST = 0;
    #1 chk("rst_mid_outs", {19'd0, ALU_GNT, RF_GNT, TX_D_VLD, TX_P_DATA, SCHED_BUSY, TX_ERR}, 32'd0);
    chk("rst_mid_bytes", bq.size(), 1);
    @(posedge CLK);
    clear_mon();
    @(negedge CLK);
    RST = 1;
    k = 0; pb = 1;
    while (!RF_GNT && k < 60) begin pb = TX_BUSY; @(negedge CLK); k++; end
    chk("rst_rel_gnt", {30'd0, k < 60, pb}, 32'd2);
    RF_REQ = 0;
    k = 0;
    while ((SCHED_BUSY || TX_BUSY) && k < 100) begin @(negedge CLK); k++; end
    @(posedge CLK);
    chk("rst_rel_done", {31'd0, k < 100}, 32'd1);
    chk("rst_rel_gq", gq.size(), 1);
    if (gq.size() > 0) chk("rst_rel_who", gq[0], 1);
    chk("rst_rel_nb", bq.size(), 1);
    if (bq.size() > 0) chk("rst_rel_byte", {24'd0, bq[0]}, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
